cacheline_adaptor: RTL and testbench
====================================

// Module: cacheline_adaptor
// PURPOSE
//  Sits directly downstream of cache_arbiter: converts its single-beat LINE_W-bit line requests (mem_read/mem_write/
//  mem_address/mem_wdata -> mem_resp/mem_rdata) into BURST_W-bit bursts on the physical-memory port.
//  Holds one line transfer at a time; the line-side response pulses exactly once per completed transfer.
// PARAMETERS
//  LINE_W   256  cache line width in bits (multiple of BURST_W)
//  BURST_W  64   physical-memory beat width in bits
//  ADDR_W   32   byte address width
//  (derived) BEATS = LINE_W/BURST_W = 4; OFFS = log2(LINE_W/8) = 5
// PORTS
//  clk        in   1        clock, all state updates on posedge
//  rst        in   1        synchronous, active-high reset
//  read_i     in   1        line read request (arbiter mem_read)
//  write_i    in   1        line write request (arbiter mem_write)
//  address_i  in   ADDR_W   line address (arbiter mem_address)
//  line_i     in   LINE_W   write line data (arbiter mem_wdata)
//  line_o     out  LINE_W   read line data (arbiter mem_rdata), valid while resp_o=1
//  resp_o     out  1        one-cycle done pulse (arbiter mem_resp)
//  read_o     out  1        burst read command to memory
//  write_o    out  1        burst write command to memory
//  address_o  out  ADDR_W   burst address, low OFFS bits forced to 0
//  burst_o    out  BURST_W  write beat data
//  burst_i    in   BURST_W  read beat data, valid when resp_i=1
//  resp_i     in   1        memory beat strobe: one beat transferred per cycle it is high
// BEHAVIOUR
//  - States: IDLE, READ, WRITE, DONE; 2-bit beat counter cnt; registered addr, LINE_W data buffer buf.
//  - Reset: state=IDLE, cnt=0, buf=0, addr=0 -> read_o=0, write_o=0, resp_o=0, line_o=0, address_o=0, burst_o=0.
//  - Outputs decode from registered state only: read_o=(READ), write_o=(WRITE), resp_o=(DONE),
//    address_o=addr, burst_o=buf[cnt*BURST_W +: BURST_W], line_o=buf.
//  - IDLE: write_i=1 -> WRITE, latch addr={address_i[ADDR_W-1:OFFS],0}, buf=line_i, cnt=0.
//    else read_i=1 -> READ, latch addr, cnt=0. write_i and read_i both 1 is illegal upstream; write wins.
//    Requests are sampled only in IDLE; changes to inputs during READ/WRITE/DONE are ignored.
//  - READ: each cycle resp_i=1 -> buf[cnt*BURST_W +: BURST_W]<=burst_i, cnt++. resp_i=0 cycles are gaps,
//    nothing captured, read_o stays 1. Beat with cnt==BEATS-1 -> DONE, cnt wraps to 0.
//  - WRITE: burst_o presents beat cnt; each cycle resp_i=1 consumes it, cnt++; beat cnt==BEATS-1 -> DONE.
//  - DONE: resp_o=1 for exactly one cycle, line_o=assembled line (reads) / written line (writes); -> IDLE.
//  - Latency (no gaps): request seen at edge E0; read_o/write_o high cycles E0..E0+k; 4 beats at consecutive resp_i;
//    resp_o high in the cycle after the last beat. Each gap cycle adds one cycle.
//  - Requester must drop or replace its request in the cycle after resp_o; IDLE treats a still-high request as new.
//  - resp_i while IDLE/DONE is ignored (no capture, no state change).
//  - rst mid-burst: next cycle state=IDLE, read_o=write_o=0, partial buf cleared, no resp_o ever issued for the
//    aborted transfer; memory model must abort on command drop.
//  - Arbiter prefetch reads are ordinary read_i requests here; no special handling.
// TESTING
//  1 Read 0x0000_1234: burst_i=0x11..11,0x22..22,0x33..33,0x44..44 with resp_i on 4 consecutive cycles ->
//    address_o=0x0000_1220, one resp_o pulse, line_o=0x44..44_33..33_22..22_11..11.
//  2 Write 0x0000_8040, line_i=0xDDDD..,0xCCCC..,0xBBBB..,0xAAAA.. (MSB..LSB) -> burst_o=A,B,C,D on successive resp_i,
//    write_o=1 until 4th beat, then single resp_o.
//  3 Read with resp_i pattern 1,0,0,1,1,0,1 -> exactly 4 captures in order, read_o held through gaps, resp_o after 7th cycle.
//  4 rst asserted after beat 2 of a read -> next cycle read_o=0, line_o=0, no resp_o; a fresh read then completes normally.
//  5 Write then read back-to-back (request changed the cycle after resp_o) -> two transfers, two resp_o pulses, readback matches.
//  6 read_i=write_i=1 in IDLE -> WRITE taken, write_o=1, read_o=0; stray resp_i in IDLE -> no state change.

Source files
------------

// File: rtl/cacheline_adaptor_if.sv
// Line-side request/response and memory-side burst signals of the cache line adaptor.
// The slave modport is the adaptor; the master modport drives requests and memory beats.
interface cacheline_adaptor_if #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
);
    logic               read_i;
    logic               write_i;
    logic [ADDR_W-1:0]  address_i;
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic               resp_o;
    logic               read_o;
    logic               write_o;
    logic [ADDR_W-1:0]  address_o;
    logic [BURST_W-1:0] burst_o;
    logic [BURST_W-1:0] burst_i;
    logic               resp_i;

    modport slave (
        input  read_i, write_i, address_i, line_i, burst_i, resp_i,
        output line_o, resp_o, read_o, write_o, address_o, burst_o
    );

    modport master (
        output read_i, write_i, address_i, line_i, burst_i, resp_i,
        input  line_o, resp_o, read_o, write_o, address_o, burst_o
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Splits single-beat cache line reads/writes into BURST_W-wide memory bursts,
// one line transfer in flight, with a one-cycle done pulse per completed transfer.
module cacheline_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    cacheline_adaptor_if.slave bus
);
    localparam int BEATS = LINE_W / BURST_W;
    localparam int OFFS  = $clog2(LINE_W / 8);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   addr;
    logic [LINE_W-1:0]   line_q;
    logic                last;

    assign last = (cnt == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr   <= '0;
            line_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A simultaneous read and write is illegal upstream; the write is honoured.
                    if (bus.write_i) begin
                        state  <= WRITE;
                        addr   <= {bus.address_i[ADDR_W-1:OFFS], {OFFS{1'b0}}};
                        line_q <= bus.line_i;
                        cnt    <= '0;
                    end else if (bus.read_i) begin
                        state <= READ;
                        addr  <= {bus.address_i[ADDR_W-1:OFFS], {OFFS{1'b0}}};
                        cnt   <= '0;
                    end
                end
                READ: begin
                    if (bus.resp_i) begin
                        line_q[cnt*BURST_W +: BURST_W] <= bus.burst_i;
                        cnt <= last ? '0 : cnt + CNT_W'(1);
                        if (last) state <= DONE;
                    end
                end
                WRITE: begin
                    if (bus.resp_i) begin
                        cnt <= last ? '0 : cnt + CNT_W'(1);
                        if (last) state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.read_o    = (state == READ);
    assign bus.write_o   = (state == WRITE);
    assign bus.resp_o    = (state == DONE);
    assign bus.address_o = addr;
    assign bus.burst_o   = line_q[cnt*BURST_W +: BURST_W];
    assign bus.line_o    = line_q;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: a memory model plus scoreboard queues of
// expected lines and write beats, pushed at stimulus time and popped as the DUT produces them.
module tb_cacheline_adaptor;
    logic clk = 1'b0;
    logic rst = 1'b1;

    cacheline_adaptor_if #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) bus ();

    cacheline_adaptor #(.LINE_W(256), .BURST_W(64), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_pulse = 0;
    int n_xfer  = 0;

    logic [255:0] mem [logic [31:0]];
    logic [255:0] q_line [$];
    logic [63:0]  q_beat [$];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (bus.resp_o === 1'b1) n_pulse++;

    // Starts at a negedge in an IDLE cycle; returns just after the edge that leaves DONE.
    task automatic do_read(input logic [31:0] a, input logic [15:0] pat, input int plen);
        logic [31:0]  al;
        logic [255:0] line;
        int k;
        al   = {a[31:5], 5'b0};
        line = mem.exists(al) ? mem[al] : '0;
        q_line.push_back(line);
        k = 0;
        @(negedge clk);
        chk("idle_resp", {255'b0, bus.resp_o}, 256'd0);
        bus.read_i = 1'b1; bus.address_i = a;
        @(negedge clk);
        bus.read_i = 1'b0; bus.address_i = $urandom;
        chk("rd_cmd", {254'b0, bus.read_o, bus.write_o}, 256'b10);
        chk("rd_addr", {224'b0, bus.address_o}, {224'b0, al});
        for (int i = 0; i < plen; i++) begin
            if (i > 0) @(negedge clk);
            chk("rd_hold", {254'b0, bus.read_o, bus.resp_o}, 256'b10);
            bus.resp_i  = pat[i];
            bus.burst_i = pat[i] ? line[k*64 +: 64] : {$urandom, $urandom};
            if (pat[i]) k++;
        end
        @(negedge clk);
        bus.resp_i = 1'b0;
        chk("rd_resp", {254'b0, bus.resp_o, bus.read_o}, 256'b10);
        chk("rd_line", bus.line_o, q_line.pop_front());
        n_xfer++;
        @(posedge clk);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [255:0] line,
                            input logic [15:0] pat, input int plen, input logic both);
        logic [31:0] al;
        al = {a[31:5], 5'b0};
        q_line.push_back(line);
        for (int b = 0; b < 4; b++) q_beat.push_back(line[b*64 +: 64]);
        @(negedge clk);
        chk("idle_resp", {255'b0, bus.resp_o}, 256'd0);
        bus.write_i = 1'b1; bus.read_i = both; bus.address_i = a; bus.line_i = line;
        @(negedge clk);
        bus.write_i = 1'b0; bus.read_i = 1'b0; bus.address_i = $urandom;
        bus.line_i = {8{$urandom}};
        chk("wr_cmd", {254'b0, bus.read_o, bus.write_o}, 256'b01);
        chk("wr_addr", {224'b0, bus.address_o}, {224'b0, al});
        for (int i = 0; i < plen; i++) begin
            if (i > 0) @(negedge clk);
            chk("wr_hold", {254'b0, bus.write_o, bus.resp_o}, 256'b10);
            bus.resp_i = pat[i];
            if (pat[i]) chk("wr_beat", {192'b0, bus.burst_o}, {192'b0, q_beat.pop_front()});
        end
        @(negedge clk);
        bus.resp_i = 1'b0;
        chk("wr_resp", {254'b0, bus.resp_o, bus.write_o}, 256'b10);
        chk("wr_line", bus.line_o, q_line.pop_front());
        mem[al] = line;
        n_xfer++;
        @(posedge clk);
    endtask

    initial begin
        logic [255:0] l1, l2, l3;
        bus.read_i = 1'b0; bus.write_i = 1'b0; bus.address_i = '0; bus.line_i = '0;
        bus.burst_i = '0; bus.resp_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd", {253'b0, bus.read_o, bus.write_o, bus.resp_o}, 256'd0);
        chk("rst_line", bus.line_o, 256'd0);
        chk("rst_addr", {224'b0, bus.address_o}, 256'd0);
        chk("rst_burst", {192'b0, bus.burst_o}, 256'd0);
        rst = 1'b0;

        // Plain read, four consecutive beats.
        l1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        mem[32'h0000_1220] = l1;
        do_read(32'h0000_1234, 16'b1111, 4);

        // Plain write, beats leave LSB first.
        l2 = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        do_write(32'h0000_8040, l2, 16'b1111, 4, 1'b0);

        // Read with gaps: pattern 1,0,0,1,1,0,1 (bit i = cycle i).
        l3 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        mem[32'h0001_0000] = l3;
        do_read(32'h0001_001F, 16'b1011001, 7);

        // Abort a read after two beats with reset.
        @(negedge clk);
        bus.read_i = 1'b1; bus.address_i = 32'h0001_0000;
        @(negedge clk);
        bus.read_i = 1'b0;
        bus.resp_i = 1'b1; bus.burst_i = l3[63:0];
        @(negedge clk);
        bus.burst_i = l3[127:64];
        @(negedge clk);
        bus.resp_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_cmd", {253'b0, bus.read_o, bus.write_o, bus.resp_o}, 256'd0);
        chk("abort_line", bus.line_o, 256'd0);
        chk("abort_addr", {224'b0, bus.address_o}, 256'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_noresp", {255'b0, bus.resp_o}, 256'd0);
        end
        do_read(32'h0001_0000, 16'b1111, 4);

        // Write then read back-to-back to the same line, with a gap in the write.
        l2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_write(32'h0000_4567, l2, 16'b11101, 5, 1'b0);
        do_read(32'h0000_4560, 16'b1111, 4);

        // Both requests high: write wins.
        l1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        do_write(32'h0000_0100, l1, 16'b1111, 4, 1'b1);

        // Stray beats while idle must not disturb anything.
        repeat (3) begin
            @(negedge clk);
            bus.resp_i = 1'b1; bus.burst_i = {$urandom, $urandom};
            chk("stray_cmd", {253'b0, bus.read_o, bus.write_o, bus.resp_o}, 256'd0);
            chk("stray_line", bus.line_o, l1);
        end
        @(negedge clk);
        bus.resp_i = 1'b0;
        chk("stray_after", {253'b0, bus.read_o, bus.write_o, bus.resp_o}, 256'd0);
        chk("stray_line2", bus.line_o, l1);
        do_read(32'h0000_0100, 16'b1111, 4);

        repeat (3) @(negedge clk);
        chk("pulses", 256'(n_pulse), 256'(n_xfer));
        chk("sb_empty", 256'(q_line.size() + q_beat.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
